// File: rtl/multi_axis_op_processor_fsm_pkg.sv
// Shared types and default parameters for the multi-axis opcode processor.
// The state enum is also exported on the debug port of the interface.
package multi_axis_op_pkg;

    typedef enum logic [0:0] {
        STANDBY   = 1'b0,
        WAIT_DONE = 1'b1
    } op_state_t;

    localparam int DEFAULT_NUM_CHANNELS  = 2;
    localparam int DEFAULT_TIMEOUT_WIDTH = 16;

endpackage

// File: rtl/multi_axis_op_processor_fsm_if.sv
// Signal bundle between the parent OP unit, the motor control units and the
// multi-axis opcode processor.
interface multi_axis_op_processor_fsm_if
#(
    parameter int NUM_CHANNELS  = multi_axis_op_pkg::DEFAULT_NUM_CHANNELS,
    parameter int TIMEOUT_WIDTH = multi_axis_op_pkg::DEFAULT_TIMEOUT_WIDTH
) ();
    import multi_axis_op_pkg::*;

    // Handshake: trigger_in with a non-zero chan_mask_in is accepted in any
    // STANDBY cycle with clk_en high; done_out drops in that same cycle and
    // rises again in the last WAIT_DONE cycle, when every selected channel has
    // pulsed done_in, abort_in is seen, or the watchdog expires.
    logic                     trigger_in;
    logic [NUM_CHANNELS-1:0]  chan_mask_in;
    logic [TIMEOUT_WIDTH-1:0] timeout_in;
    logic                     abort_in;
    logic [NUM_CHANNELS-1:0]  done_in;
    logic [NUM_CHANNELS-1:0]  trigger_out;
    logic                     done_out;
    logic                     busy;
    logic [NUM_CHANNELS-1:0]  pending;
    logic                     timeout_err;
    op_state_t                state_dbg;

    modport master (
        output trigger_in, chan_mask_in, timeout_in, abort_in, done_in,
        input  trigger_out, done_out, busy, pending, timeout_err, state_dbg
    );

    modport slave (
        input  trigger_in, chan_mask_in, timeout_in, abort_in, done_in,
        output trigger_out, done_out, busy, pending, timeout_err, state_dbg
    );

endinterface

// File: rtl/multi_axis_op_processor_fsm_op_watchdog_counter.sv
// Watchdog counter for one operation: counts enabled cycles from zero and
// flags the cycle in which the count reaches limit-1; limit 0 never expires.
module op_watchdog_counter
#(
    parameter int TIMEOUT_WIDTH = multi_axis_op_pkg::DEFAULT_TIMEOUT_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     enable,
    input  logic [TIMEOUT_WIDTH-1:0] limit,
    output logic                     expire
);

    logic [TIMEOUT_WIDTH-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + TIMEOUT_WIDTH'(1);
        end
    end

    assign expire = (limit != '0) && (count == (limit - TIMEOUT_WIDTH'(1)));

endmodule

// File: rtl/multi_axis_op_processor_fsm.sv
// Fans one parent trigger out to a masked set of motor channels, tracks each
// channel's done as a sticky pending bit, and ends on completion/abort/watchdog.
module multi_axis_op_processor_fsm
    import multi_axis_op_pkg::*;
#(
    parameter int NUM_CHANNELS  = DEFAULT_NUM_CHANNELS,
    parameter int TIMEOUT_WIDTH = DEFAULT_TIMEOUT_WIDTH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clk_en,
    multi_axis_op_processor_fsm_if.slave  bus
);

    op_state_t                state;
    op_state_t                state_next;
    logic [NUM_CHANNELS-1:0]  pending_q;
    logic [NUM_CHANNELS-1:0]  remaining;
    logic [TIMEOUT_WIDTH-1:0] limit_q;
    logic                     timeout_err_q;
    logic                     accept;
    logic                     all_done;
    logic                     expire;
    logic                     end_abort;
    logic                     end_complete;
    logic                     end_timeout;
    logic                     wd_clear;
    logic                     wd_enable;

    // Priority inside WAIT_DONE: abort, then completion, then watchdog.
    assign remaining    = pending_q & ~bus.done_in;
    assign all_done     = (remaining == '0);
    assign accept       = (state == STANDBY) && bus.trigger_in && (bus.chan_mask_in != '0);
    assign end_abort    = (state == WAIT_DONE) && bus.abort_in;
    assign end_complete = (state == WAIT_DONE) && !bus.abort_in && all_done;
    assign end_timeout  = (state == WAIT_DONE) && !bus.abort_in && !all_done && expire;
    assign wd_clear     = clk_en && accept;
    assign wd_enable    = clk_en && (state == WAIT_DONE) && !end_abort && !end_complete && !end_timeout;

    op_watchdog_counter #(
        .TIMEOUT_WIDTH (TIMEOUT_WIDTH)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (wd_clear),
        .enable (wd_enable),
        .limit  (limit_q),
        .expire (expire)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= STANDBY;
        end else if (clk_en) begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            STANDBY: begin
                if (accept) begin
                    state_next = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (end_abort || end_complete || end_timeout) begin
                    state_next = STANDBY;
                end
            end
            default: state_next = STANDBY;
        endcase
    end

    always_comb begin
        bus.trigger_out = '0;
        bus.done_out    = 1'b1;
        bus.busy        = 1'b0;
        case (state)
            STANDBY: begin
                if (accept) begin
                    bus.trigger_out = bus.chan_mask_in;
                    bus.done_out    = 1'b0;
                end
            end
            WAIT_DONE: begin
                bus.busy     = 1'b1;
                bus.done_out = end_abort || end_complete || end_timeout;
            end
            default: begin
                bus.done_out = 1'b1;
            end
        endcase
    end

    // A done pulse is remembered by dropping its pending bit for good.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q     <= '0;
            limit_q       <= '0;
            timeout_err_q <= 1'b0;
        end else if (clk_en) begin
            if (accept) begin
                pending_q     <= bus.chan_mask_in;
                limit_q       <= bus.timeout_in;
                timeout_err_q <= 1'b0;
            end else if (state == WAIT_DONE) begin
                if (end_abort || end_complete || end_timeout) begin
                    pending_q <= '0;
                end else begin
                    pending_q <= remaining;
                end
                if (end_timeout) begin
                    timeout_err_q <= 1'b1;
                end
            end
        end
    end

    assign bus.pending     = pending_q;
    assign bus.timeout_err = timeout_err_q;
    assign bus.state_dbg   = state;

endmodule

// File: tb/tb_multi_axis_op_processor_fsm.sv
// Randomized scoreboard bench for multi_axis_op_processor_fsm with a
// per-operation reference model of how and when each operation must end.
module tb_multi_axis_op_processor_fsm;
    import multi_axis_op_pkg::*;

    localparam int NC = 3;
    localparam int TW = 16;

    logic clk;
    logic reset;
    logic clk_en;

    multi_axis_op_processor_fsm_if #(.NUM_CHANNELS(NC), .TIMEOUT_WIDTH(TW)) bus ();

    multi_axis_op_processor_fsm #(
        .NUM_CHANNELS  (NC),
        .TIMEOUT_WIDTH (TW)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .clk_en (clk_en),
        .bus    (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL sim_timeout: got no finish, expected finish before time limit");
        $fatal(1, "bench time limit");
    end

    // ---------------- scoreboard state ----------------
    int n_cmp;
    int n_bad;
    logic [NC-1:0] exp_trig_q[$];
    logic [15:0]   exp_op_q[$];   // {timeout_err, enabled WAIT_DONE cycles}

    logic [NC-1:0] plan_done  [1:16];
    logic          plan_abort [1:16];
    int            plan_dis   [1:16];
    logic [NC-1:0] acc_done_in;

    int   wcnt;
    logic err_chk;
    logic exp_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: walk the enabled WAIT_DONE cycles as sets of finished
    // channels and report the cycle the operation ends in and why.
    function automatic logic [15:0] model_op(input logic [NC-1:0] mask, input int lim, input int n);
        logic [NC-1:0] seen;
        seen = '0;
        for (int k = 1; k <= n; k++) begin
            if (plan_abort[k]) return {1'b0, 15'(k)};
            seen = seen | (plan_done[k] & mask);
            if (seen == mask) return {1'b0, 15'(k)};
            if (lim != 0 && k == lim) return {1'b1, 15'(k)};
        end
        return {1'b0, 15'(n)};
    endfunction

    task automatic clear_plan(input int n);
        for (int k = 1; k <= 16; k++) begin
            plan_done[k]  = '0;
            plan_abort[k] = 1'b0;
            plan_dis[k]   = 0;
        end
        plan_done[n] = '1;
        acc_done_in  = '0;
    endtask

    task automatic step_idle();
        @(posedge clk); #1;
        clk_en           = 1'b1;
        bus.trigger_in   = 1'b0;
        bus.chan_mask_in = '0;
        bus.timeout_in   = '0;
        bus.abort_in     = 1'b0;
        bus.done_in      = '0;
        @(negedge clk);
    endtask

    // ---------------- driver tasks ----------------
    task automatic run_op(input logic [NC-1:0] mask, input int lim, input int n);
        logic [15:0]   res;
        logic [NC-1:0] seen;
        int            e;
        res = model_op(mask, lim, n);
        e   = int'(res[14:0]);
        exp_trig_q.push_back(mask);
        exp_op_q.push_back(res);

        @(posedge clk); #1;
        clk_en           = 1'b1;
        bus.trigger_in   = 1'b1;
        bus.chan_mask_in = mask;
        bus.timeout_in   = TW'(lim);
        bus.abort_in     = 1'b0;
        bus.done_in      = acc_done_in;
        @(negedge clk);
        check("accept_done_out", 32'(bus.done_out), 32'd0);

        seen = '0;
        for (int k = 1; k <= e; k++) begin
            for (int d = 0; d < plan_dis[k]; d++) begin
                @(posedge clk); #1;
                clk_en           = 1'b0;
                bus.trigger_in   = 1'b0;
                bus.abort_in     = 1'b0;
                bus.done_in      = NC'($urandom);
                @(negedge clk);
                check("pending_hold", 32'(bus.pending), 32'(mask & ~seen));
            end
            @(posedge clk); #1;
            clk_en           = 1'b1;
            bus.trigger_in   = 1'($urandom);
            bus.chan_mask_in = NC'($urandom_range(1, (1 << NC) - 1));
            bus.timeout_in   = TW'($urandom_range(1, 3));
            bus.done_in      = plan_done[k];
            bus.abort_in     = plan_abort[k];
            @(negedge clk);
            check("pending", 32'(bus.pending), 32'(mask & ~seen));
            check("busy_wait", 32'(bus.busy), 32'd1);
            seen = seen | (plan_done[k] & mask);
        end
    endtask

    task automatic run_zero_mask();
        @(posedge clk); #1;
        clk_en           = 1'b1;
        bus.trigger_in   = 1'b1;
        bus.chan_mask_in = '0;
        bus.timeout_in   = TW'($urandom_range(0, 5));
        bus.abort_in     = 1'b0;
        bus.done_in      = NC'($urandom);
        @(negedge clk);
        check("zero_mask_trigger", 32'(bus.trigger_out), 32'd0);
        check("zero_mask_done", 32'(bus.done_out), 32'd1);
        step_idle();
        check("zero_mask_busy", 32'(bus.busy), 32'd0);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!reset) begin
            if (err_chk) begin
                err_chk = 1'b0;
                check("end_timeout_err", 32'(bus.timeout_err), 32'(exp_err));
                check("end_standby", 32'(bus.busy), 32'd0);
                check("end_pending", 32'(bus.pending), 32'd0);
            end
            if (bus.trigger_out != '0) begin
                wcnt = 0;
                if (exp_trig_q.size() == 0) begin
                    check("unexpected_trigger", 32'(bus.trigger_out), 32'd0);
                end else begin
                    check("trigger_out", 32'(bus.trigger_out), 32'(exp_trig_q.pop_front()));
                end
            end
            if (bus.busy && clk_en) begin
                wcnt++;
                if (bus.done_out) begin
                    if (exp_op_q.size() == 0) begin
                        check("unexpected_end", 32'(wcnt), 32'd0);
                    end else begin
                        logic [15:0] r;
                        r = exp_op_q.pop_front();
                        check("op_length", 32'(wcnt), 32'(r[14:0]));
                        exp_err = r[15];
                        err_chk = 1'b1;
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        n_cmp = 0;
        n_bad = 0;
        wcnt = 0;
        err_chk = 1'b0;
        exp_err = 1'b0;
        reset = 1'b1;
        clk_en = 1'b0;
        bus.trigger_in = 1'b0;
        bus.chan_mask_in = '0;
        bus.timeout_in = '0;
        bus.abort_in = 1'b0;
        bus.done_in = '0;
        clear_plan(1);

        repeat (3) @(negedge clk);
        check("rst_done_out", 32'(bus.done_out), 32'd1);
        check("rst_trigger_out", 32'(bus.trigger_out), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_pending", 32'(bus.pending), 32'd0);
        check("rst_timeout_err", 32'(bus.timeout_err), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        step_idle();

        // Two channels finishing in different cycles.
        clear_plan(5);
        plan_done[2] = 3'b001;
        plan_done[5] = 3'b100;
        run_op(3'b101, 0, 5);
        // All dones already high: minimum latency, back-to-back accept.
        clear_plan(1);
        plan_done[1] = 3'b111;
        acc_done_in  = 3'b111;
        run_op(3'b011, 0, 1);
        run_zero_mask();
        // Watchdog expiry, then a completion that coincides with the limit.
        clear_plan(10);
        run_op(3'b111, 4, 10);
        clear_plan(6);
        plan_done[2] = 3'b001;
        plan_done[4] = 3'b010;
        run_op(3'b011, 4, 6);
        // Abort, then a watchdog run with disabled cycles mid-operation.
        clear_plan(6);
        plan_abort[2] = 1'b1;
        run_op(3'b111, 0, 6);
        clear_plan(6);
        plan_dis[2] = 2;
        run_op(3'b011, 3, 6);
        step_idle();

        for (int i = 0; i < 40; i++) begin
            int n;
            if ($urandom_range(0, 7) == 0) run_zero_mask();
            n = $urandom_range(1, 10);
            clear_plan(n);
            for (int k = 1; k < n; k++) begin
                plan_done[k]  = ($urandom_range(0, 2) == 0) ? NC'($urandom) : '0;
                plan_abort[k] = ($urandom_range(0, 14) == 0);
            end
            for (int k = 1; k <= n; k++) begin
                plan_dis[k] = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 2) : 0;
            end
            acc_done_in = NC'($urandom);
            run_op(NC'($urandom_range(1, (1 << NC) - 1)),
                   ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 8), n);
            if ($urandom_range(0, 3) == 0) step_idle();
        end
        step_idle();

        // Reset in the middle of an operation.
        exp_trig_q.push_back(3'b111);
        @(posedge clk); #1;
        bus.trigger_in   = 1'b1;
        bus.chan_mask_in = 3'b111;
        bus.timeout_in   = '0;
        bus.done_in      = '0;
        @(posedge clk); #1;
        bus.trigger_in   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("pre_reset_busy", 32'(bus.busy), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_pending", 32'(bus.pending), 32'd0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_done_out", 32'(bus.done_out), 32'd1);
        check("mid_rst_trigger", 32'(bus.trigger_out), 32'd0);
        exp_op_q.delete();
        err_chk = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        step_idle();
        check("post_rst_state", 32'(bus.state_dbg), 32'(STANDBY));
        check("post_rst_pending", 32'(bus.pending), 32'd0);

        clear_plan(2);
        plan_done[1] = 3'b001;
        run_op(3'b101, 0, 2);
        repeat (5) step_idle();
        check("trig_queue_empty", 32'(exp_trig_q.size()), 32'd0);
        check("op_queue_empty", 32'(exp_op_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
